// File: rtl/ajuste_pkg.sv
// Shared definitions for the clock/date setting front end: field codes,
// controller state encoding and field-cycling helpers.
package ajuste_pkg;

  localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
  localparam logic [3:0] CAMPO_HORA    = 4'd1;
  localparam logic [3:0] CAMPO_MIN     = 4'd2;
  localparam logic [3:0] CAMPO_SEG     = 4'd3;
  localparam logic [3:0] CAMPO_DIA     = 4'd4;
  localparam logic [3:0] CAMPO_MES     = 4'd5;
  localparam logic [3:0] CAMPO_ANIO    = 4'd6;
  localparam logic [3:0] CAMPO_TH      = 4'd7;
  localparam logic [3:0] CAMPO_TM      = 4'd8;
  localparam logic [3:0] CAMPO_TS      = 4'd9;

  typedef enum logic {
    NORMAL = 1'b0,
    AJUSTE = 1'b1
  } estado_t;

  // Next field, wrapping from the last field back to the first one.
  function automatic logic [3:0] campo_siguiente(input logic [3:0] campo,
                                                 input logic [3:0] n_campos);
    return (campo >= n_campos) ? CAMPO_HORA : campo + 4'd1;
  endfunction

  // Previous field, wrapping from the first field to the last one.
  function automatic logic [3:0] campo_anterior(input logic [3:0] campo,
                                                input logic [3:0] n_campos);
    return (campo <= CAMPO_HORA) ? n_campos : campo - 4'd1;
  endfunction

endpackage

// File: rtl/pulso_repeticion.sv
// One step channel: press-edge detection plus hold-to-repeat timing.
// The pulse output is combinational; the top registers it after applying
// its own priority and suppression rules.
module pulso_repeticion #(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 13_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic enable,
  input  logic restart,
  output logic press,
  output logic pulse
);

  localparam int MAX_P = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W = ($clog2(MAX_P) < 1) ? 1 : $clog2(MAX_P);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fase_q, fase_d;   // 0: waiting first repeat, 1: periodic
  logic [CNT_W-1:0] limite;

  // Edge detect and repeat counter; any idle/restart condition rearms the delay.
  always_comb begin
    prev_d = level;
    press  = level & ~prev_q;
    limite = fase_q ? PERIOD_LAST : DELAY_LAST;
    pulse  = 1'b0;
    cnt_d  = '0;
    fase_d = 1'b0;
    if (enable && !restart && level) begin
      if (press) begin
        pulse = 1'b1;
      end else if (cnt_q == limite) begin
        pulse  = 1'b1;
        fase_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        fase_d = fase_q;
      end
    end
  end

  // State registers; previous sample resets high so a held button is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
      fase_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      fase_q <= fase_d;
    end
  end

endmodule

// File: rtl/control_ajuste_campos.sv
// Setting-mode controller: selects the active field and issues single-cycle
// Arriba/Abajo step pulses from debounced button levels, with inactivity exit.
module control_ajuste_campos
  import ajuste_pkg::*;
#(
  parameter int N_CAMPOS      = 9,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 13_000_000,
  parameter int TIMEOUT       = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_config,
  input  logic       btn_der,
  input  logic       btn_izq,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  output logic [3:0] contadoresH,
  output logic       Arriba,
  output logic       Abajo,
  output logic       modo_config
);

  localparam int               TMO_W      = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]       N_CAMPOS_C = 4'(N_CAMPOS);

  estado_t          estado_q, estado_d;
  logic [3:0]       campo_q, campo_d;
  logic             arriba_q, arriba_d;
  logic             abajo_q, abajo_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             cfg_prev_q, der_prev_q, izq_prev_q;

  logic       flanco_cfg, flanco_der, flanco_izq, cambio_campo;
  logic       reiniciar, en_ajuste, actividad, tmo_fin;
  logic [1:0] nivel, press, req;

  assign flanco_cfg   = btn_config & ~cfg_prev_q;
  assign flanco_der   = btn_der & ~der_prev_q;
  assign flanco_izq   = btn_izq & ~izq_prev_q;
  assign cambio_campo = flanco_der ^ flanco_izq;   // both together cancel out
  assign reiniciar    = flanco_cfg | cambio_campo;
  assign en_ajuste    = (estado_q == AJUSTE);

  // Masking each step level with the other one keeps both channels idle while
  // both are held and makes the survivor look like a fresh press afterwards.
  assign nivel[0] = btn_arriba & ~btn_abajo;
  assign nivel[1] = btn_abajo & ~btn_arriba;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_canal
      pulso_repeticion #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_pulso (
        .clk    (clk),
        .reset  (reset),
        .level  (nivel[gi]),
        .enable (en_ajuste),
        .restart(reiniciar),
        .press  (press[gi]),
        .pulse  (req[gi])
      );
    end
  endgenerate

  // Press edges count as activity and win over the timeout; repeat pulses do not.
  assign actividad = flanco_cfg | flanco_der | flanco_izq | (|press);
  assign tmo_fin   = (tmo_q == TMO_LAST) && !actividad;

  // Next-state logic: config edge, then field change, then timeout/step.
  always_comb begin
    estado_d = estado_q;
    campo_d  = campo_q;
    arriba_d = 1'b0;
    abajo_d  = 1'b0;
    tmo_d    = '0;
    case (estado_q)
      NORMAL: begin
        if (flanco_cfg) begin
          estado_d = AJUSTE;
          campo_d  = CAMPO_HORA;
        end
      end
      AJUSTE: begin
        if (flanco_cfg) begin
          estado_d = NORMAL;
          campo_d  = CAMPO_NINGUNO;
        end else if (cambio_campo) begin
          campo_d = flanco_der ? campo_siguiente(campo_q, N_CAMPOS_C)
                               : campo_anterior(campo_q, N_CAMPOS_C);
        end else if (tmo_fin) begin
          estado_d = NORMAL;
          campo_d  = CAMPO_NINGUNO;
        end else begin
          arriba_d = req[0];
          abajo_d  = req[1];
          tmo_d    = (actividad || (|req)) ? '0 : tmo_q + TMO_W'(1);
        end
      end
      default: begin
        estado_d = NORMAL;
        campo_d  = CAMPO_NINGUNO;
      end
    endcase
  end

  // Controller registers; previous-sample registers reset high.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= NORMAL;
      campo_q    <= CAMPO_NINGUNO;
      arriba_q   <= 1'b0;
      abajo_q    <= 1'b0;
      tmo_q      <= '0;
      cfg_prev_q <= 1'b1;
      der_prev_q <= 1'b1;
      izq_prev_q <= 1'b1;
    end else begin
      estado_q   <= estado_d;
      campo_q    <= campo_d;
      arriba_q   <= arriba_d;
      abajo_q    <= abajo_d;
      tmo_q      <= tmo_d;
      cfg_prev_q <= btn_config;
      der_prev_q <= btn_der;
      izq_prev_q <= btn_izq;
    end
  end

  assign contadoresH = campo_q;
  assign Arriba      = arriba_q;
  assign Abajo       = abajo_q;
  assign modo_config = (estado_q == AJUSTE);

endmodule
